// File: rtl/md_ctrl_pkg.sv
// Shared encodings and latency defaults for the HI/LO multiply/divide unit.
package md_ctrl_pkg;

   localparam logic [5:0] OPCODE_SPECIAL = 6'b000000;
   localparam logic [5:0] FUNCT_MULT     = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU    = 6'b011001;
   localparam logic [5:0] FUNCT_DIV      = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU     = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI     = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO     = 6'b010010;
   localparam logic [5:0] FUNCT_MTHI     = 6'b010001;
   localparam logic [5:0] FUNCT_MTLO     = 6'b010011;

   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   function automatic logic is_div_op(input md_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Strobe/operand/result bundle between the E-stage pipeline and the HI/LO unit.
interface md_ctrl_if;
   logic        mult;
   logic        multu;
   logic        div;
   logic        divu;
   logic        mthi;
   logic        mtlo;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output mult, multu, div, divu, mthi, mtlo, A, B,
      input  start, busy, md_stall, HI, LO
   );

   modport slave (
      input  mult, multu, div, divu, mthi, mtlo, A, B,
      output start, busy, md_stall, HI, LO
   );
endinterface

// File: rtl/md_ctrl_alu.sv
// Combinational multiply/divide core: result is {HI, LO}; div result is {remainder, quotient}.
module md_alu
   import md_ctrl_pkg::*;
(
   input  md_op_t      op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic        [31:0] b_u;
   logic        [31:0] quot_u;
   logic        [31:0] rem_u;

   assign div_by_zero = (B == 32'd0);

   // Sign-extended 64-bit operands make the truncated product the exact signed product.
   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Divisor forced to 1 on zero so the datapath never produces X; the result is discarded anyway.
   assign a_s    = $signed(A);
   assign b_s    = div_by_zero ? 32'sd1 : $signed(B);
   assign b_u    = div_by_zero ? 32'd1 : B;
   assign quot_s = a_s / b_s;
   assign rem_s  = a_s % b_s;
   assign quot_u = A / b_u;
   assign rem_u  = A % b_u;

   always_comb begin
      result = 64'd0;
      case (op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV:   result = {rem_s, quot_s};
         OP_DIVU:  result = {rem_u, quot_u};
         default:  result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// Fixed-latency HI/LO multiply/divide controller: captures the result at start,
// holds busy for the configured latency, then commits to HI/LO.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   md_ctrl_if.slave   bus
);

   md_state_t   state, state_n;
   logic [3:0]  count, count_n;
   logic [31:0] hi, hi_n;
   logic [31:0] lo, lo_n;
   logic [31:0] pend_hi, pend_hi_n;
   logic [31:0] pend_lo, pend_lo_n;
   logic        pend_ok, pend_ok_n;

   md_op_t      op_sel;
   logic [63:0] alu_result;
   logic        alu_dbz;
   logic        start;

   assign start = bus.mult | bus.multu | bus.div | bus.divu;

   // Priority only matters on illegal overlap; the decoder drives one-hot strobes.
   always_comb begin
      op_sel = OP_DIVU;
      if      (bus.mult)  op_sel = OP_MULT;
      else if (bus.multu) op_sel = OP_MULTU;
      else if (bus.div)   op_sel = OP_DIV;
   end

   md_alu u_alu (
      .op          (op_sel),
      .A           (bus.A),
      .B           (bus.B),
      .result      (alu_result),
      .div_by_zero (alu_dbz)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= 4'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_ok <= 1'b0;
      end else begin
         state   <= state_n;
         count   <= count_n;
         hi      <= hi_n;
         lo      <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
         pend_ok <= pend_ok_n;
      end
   end

   always_comb begin
      state_n   = state;
      count_n   = count;
      hi_n      = hi;
      lo_n      = lo;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      pend_ok_n = pend_ok;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n   = ST_BUSY;
               count_n   = is_div_op(op_sel) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
               pend_hi_n = alu_result[63:32];
               pend_lo_n = alu_result[31:0];
               pend_ok_n = !(is_div_op(op_sel) && alu_dbz);
            end else if (bus.mthi) begin
               hi_n = bus.A;
            end else if (bus.mtlo) begin
               lo_n = bus.A;
            end
         end
         ST_BUSY: begin
            // All strobes are ignored here; the hazard unit is expected to stall instead.
            count_n = count - 4'd1;
            if (count == 4'd1) begin
               state_n = ST_IDLE;
               if (pend_ok) begin
                  hi_n = pend_hi;
                  lo_n = pend_lo;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            count_n = 4'd0;
         end
      endcase
   end

   assign bus.start    = start;
   assign bus.busy     = (count != 4'd0);
   assign bus.md_stall = start | (count != 4'd0);
   assign bus.HI       = hi;
   assign bus.LO       = lo;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed-vector bench for md_ctrl with hand-computed HI/LO results and busy windows.
module tb_md_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   localparam int K_MULT  = 0;
   localparam int K_MULTU = 1;
   localparam int K_DIV   = 2;
   localparam int K_DIVU  = 3;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   md_ctrl_if bus ();

   md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_strobes();
      bus.mult  = 1'b0;
      bus.multu = 1'b0;
      bus.div   = 1'b0;
      bus.divu  = 1'b0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
   endtask

   // Issue an op in the current cycle, check every busy cycle, end in the first idle cycle.
   task automatic op_run(input string name, input int kind, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit poke_mthi);
      clear_strobes();
      bus.A = a;
      bus.B = b;
      case (kind)
         K_MULT:  bus.mult  = 1'b1;
         K_MULTU: bus.multu = 1'b1;
         K_DIV:   bus.div   = 1'b1;
         default: bus.divu  = 1'b1;
      endcase
      #1;
      check({name, " start"}, 32'(bus.start), 32'd1);
      check({name, " stall@T"}, 32'(bus.md_stall), 32'd1);
      check({name, " busy@T"}, 32'(bus.busy), 32'd0);
      tick();
      clear_strobes();
      for (int i = 1; i <= n; i++) begin
         if (poke_mthi && i == 3) begin
            bus.mthi = 1'b1;
            bus.A    = 32'h55;
         end else begin
            bus.mthi = 1'b0;
         end
         #1;
         check($sformatf("%s busy c%0d", name, i), 32'(bus.busy), 32'd1);
         check($sformatf("%s stall c%0d", name, i), 32'(bus.md_stall), 32'd1);
         check($sformatf("%s oldHI c%0d", name, i), bus.HI, old_hi);
         check($sformatf("%s oldLO c%0d", name, i), bus.LO, old_lo);
         tick();
      end
      clear_strobes();
      #1;
      check({name, " busy end"}, 32'(bus.busy), 32'd0);
      check({name, " HI"}, bus.HI, exp_hi);
      check({name, " LO"}, bus.LO, exp_lo);
   endtask

   initial begin
      reset = 1'b1;
      clear_strobes();
      bus.A = 32'd0;
      bus.B = 32'd0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst stall", 32'(bus.md_stall), 32'd0);
      check("rst start", 32'(bus.start), 32'd0);
      check("rst HI", bus.HI, 32'd0);
      check("rst LO", bus.LO, 32'd0);

      op_run("mult", K_MULT, 32'hFFFFFFFF, 32'h2, MC, 32'h0, 32'h0,
             32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      op_run("multu", K_MULTU, 32'hFFFFFFFF, 32'h2, MC, 32'hFFFFFFFF, 32'hFFFFFFFE,
             32'h00000001, 32'hFFFFFFFE, 1'b0);
      op_run("div", K_DIV, 32'hFFFFFFF9, 32'h2, DC, 32'h1, 32'hFFFFFFFE,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      op_run("div negB", K_DIV, 32'h7, 32'hFFFFFFFE, DC, 32'hFFFFFFFF, 32'hFFFFFFFD,
             32'h1, 32'hFFFFFFFD, 1'b0);
      op_run("divu", K_DIVU, 32'h7, 32'h2, DC, 32'h1, 32'hFFFFFFFD,
             32'h1, 32'h3, 1'b0);

      bus.mthi = 1'b1;
      bus.A    = 32'h11;
      tick();
      bus.mthi = 1'b0;
      bus.mtlo = 1'b1;
      bus.A    = 32'h22;
      #1;
      check("mthi HI", bus.HI, 32'h11);
      check("mthi busy", 32'(bus.busy), 32'd0);
      tick();
      clear_strobes();
      #1;
      check("mtlo LO", bus.LO, 32'h22);
      check("mtlo HI kept", bus.HI, 32'h11);

      op_run("div0", K_DIV, 32'h1234, 32'h0, DC, 32'h11, 32'h22,
             32'h11, 32'h22, 1'b1);

      bus.mthi = 1'b1;
      bus.A    = 32'h55;
      tick();
      clear_strobes();
      #1;
      check("mthi idle HI", bus.HI, 32'h55);
      check("mthi idle busy", 32'(bus.busy), 32'd0);

      bus.multu = 1'b1;
      bus.A     = 32'd3;
      bus.B     = 32'd4;
      tick();
      clear_strobes();
      #1;
      check("abort busy c2", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort HI", bus.HI, 32'd0);
      check("abort LO", bus.LO, 32'd0);
      tick();
      tick();
      tick();
      check("abort nocommit LO", bus.LO, 32'd0);
      check("abort nocommit HI", bus.HI, 32'd0);
      check("abort idle", 32'(bus.busy), 32'd0);

      op_run("b2b mult", K_MULT, 32'd3, 32'd4, MC, 32'h0, 32'h0,
             32'h0, 32'd12, 1'b0);
      op_run("b2b div", K_DIV, 32'd12, 32'd5, DC, 32'h0, 32'd12,
             32'd2, 32'd2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
